// File: rtl/accel_top_level.sv
// Data mover between a single-port sample RAM and two streaming accelerators:
// samples are broadcast into the FFT and FIR input FIFOs, and results are written back to RAM.

module accel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
  assign push_ok = push && (count != FULL_CNT);
  assign pop_ok  = pop && (count != '0);
  assign rdata   = (count == '0) ? '0 : mem[rd_idx];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_idx <= wr_idx + 1'b1;
      if (pop_ok)  rd_idx <= rd_idx + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_idx] <= wdata;
  end
endmodule

module accel_top_level #(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          NUM_SAMPLES  = 44100,
  parameter logic [31:0] FFT_OUT_BASE = 32'h0001_0000,
  parameter logic [31:0] FIR_OUT_BASE = 32'h0002_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acc_fft_get,
  input  logic        acc_fir_get,
  input  logic        acc_fft_put,
  input  logic        acc_fir_put,
  input  logic [31:0] acc_fft_data_in,
  input  logic [31:0] acc_fir_data_in,
  output logic [31:0] acc_fft_data_out,
  output logic [31:0] acc_fir_data_out,
  output logic        fft_enable,
  output logic        fir_enable,
  output logic        to_fft_empty,
  output logic        to_fir_empty,
  output logic        from_fft_full,
  output logic        from_fir_full,
  inout  wire  [31:0] data_bus,
  output logic        ram_read_enable,
  output logic        ram_write_enable,
  output logic [31:0] addr
);
  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [31:0] NS          = 32'(NUM_SAMPLES);
  localparam logic [31:0] LAST_SAMPLE = 32'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {OP_IDLE, OP_WR_FFT, OP_WR_FIR, OP_READ} bus_op_e;

  bus_op_e       op_q, op_nx;
  logic [31:0]   rd_ptr, fft_wr_ptr, fir_wr_ptr;
  logic [31:0]   rd_ptr_nx, fft_wr_nx, fir_wr_nx, addr_nx;
  logic [CW-1:0] to_fft_count, to_fir_count, from_fft_count, from_fir_count;
  logic [CW-1:0] to_fft_next, to_fir_next;
  logic [31:0]   from_fft_head, from_fir_head;
  logic          fft_avail, fir_avail, read_ok;

  accel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_to_fft (
    .clk(clk), .reset(reset), .push(op_q == OP_READ), .pop(acc_fft_get),
    .wdata(data_bus), .rdata(acc_fft_data_out), .count(to_fft_count)
  );
  accel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_to_fir (
    .clk(clk), .reset(reset), .push(op_q == OP_READ), .pop(acc_fir_get),
    .wdata(data_bus), .rdata(acc_fir_data_out), .count(to_fir_count)
  );
  accel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_from_fft (
    .clk(clk), .reset(reset), .push(acc_fft_put), .pop(op_q == OP_WR_FFT),
    .wdata(acc_fft_data_in), .rdata(from_fft_head), .count(from_fft_count)
  );
  accel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_from_fir (
    .clk(clk), .reset(reset), .push(acc_fir_put), .pop(op_q == OP_WR_FIR),
    .wdata(acc_fir_data_in), .rdata(from_fir_head), .count(from_fir_count)
  );

  assign to_fft_empty  = (to_fft_count == '0);
  assign to_fir_empty  = (to_fir_count == '0);
  assign from_fft_full = (from_fft_count == FULL_CNT);
  assign from_fir_full = (from_fir_count == FULL_CNT);
  assign fft_enable    = ~to_fft_empty;
  assign fir_enable    = ~to_fir_empty;

  // The head of the selected output FIFO is stable for the whole write cycle.
  assign data_bus = ram_write_enable ? ((op_q == OP_WR_FFT) ? from_fft_head : from_fir_head) : 'z;

  // Input FIFO occupancy after this edge, including the read that closes and any accelerator get.
  assign to_fft_next = to_fft_count + CW'(op_q == OP_READ) - CW'(acc_fft_get && !to_fft_empty);
  assign to_fir_next = to_fir_count + CW'(op_q == OP_READ) - CW'(acc_fir_get && !to_fir_empty);

  // A result pushed on this edge is only eligible from the next edge; our own pop is discounted.
  assign fft_avail = from_fft_count > CW'(op_q == OP_WR_FFT);
  assign fir_avail = from_fir_count > CW'(op_q == OP_WR_FIR);

  assign rd_ptr_nx = rd_ptr + 32'(op_q == OP_READ);
  assign fft_wr_nx = (op_q != OP_WR_FFT) ? fft_wr_ptr :
                     (fft_wr_ptr == LAST_SAMPLE) ? '0 : fft_wr_ptr + 32'd1;
  assign fir_wr_nx = (op_q != OP_WR_FIR) ? fir_wr_ptr :
                     (fir_wr_ptr == LAST_SAMPLE) ? '0 : fir_wr_ptr + 32'd1;
  assign read_ok   = (rd_ptr_nx < NS) && (to_fft_next < FULL_CNT) && (to_fir_next < FULL_CNT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op_nx   = OP_IDLE;
    addr_nx = addr;
    if (fft_avail) begin
      op_nx   = OP_WR_FFT;
      addr_nx = FFT_OUT_BASE + fft_wr_nx;
    end else if (fir_avail) begin
      op_nx   = OP_WR_FIR;
      addr_nx = FIR_OUT_BASE + fir_wr_nx;
    end else if (read_ok) begin
      op_nx   = OP_READ;
      addr_nx = rd_ptr_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q             <= OP_IDLE;
      rd_ptr           <= '0;
      fft_wr_ptr       <= '0;
      fir_wr_ptr       <= '0;
      addr             <= '0;
      ram_read_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
    end else begin
      op_q             <= op_nx;
      rd_ptr           <= rd_ptr_nx;
      fft_wr_ptr       <= fft_wr_nx;
      fir_wr_ptr       <= fir_wr_nx;
      addr             <= addr_nx;
      ram_read_enable  <= (op_nx == OP_READ);
      ram_write_enable <= (op_nx == OP_WR_FFT) || (op_nx == OP_WR_FIR);
    end
  end
endmodule

// File: tb/tb_accel_top_level.sv
// Scoreboard bench for accel_top_level: a queue-based model predicts FIFO heads, read order
// and writeback words; a negedge monitor compares every bus cycle and accelerator-side output.

module tb_accel_top_level;
  localparam int          NS        = 20;
  localparam int          DEPTH     = 16;
  localparam logic [31:0] FFT_BASE  = 32'h0001_0000;
  localparam logic [31:0] FIR_BASE  = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        acc_fft_get = 1'b0, acc_fir_get = 1'b0;
  logic        acc_fft_put = 1'b0, acc_fir_put = 1'b0;
  logic [31:0] acc_fft_data_in = '0, acc_fir_data_in = '0;
  logic [31:0] acc_fft_data_out, acc_fir_data_out;
  logic        fft_enable, fir_enable, to_fft_empty, to_fir_empty, from_fft_full, from_fir_full;
  logic        ram_read_enable, ram_write_enable;
  logic [31:0] addr;
  wire  [31:0] data_bus;

  // RAM with zero read latency: mem[a] = a + 100.
  assign data_bus = ram_read_enable ? addr + 32'd100 : 'z;

  accel_top_level #(
    .FIFO_DEPTH(DEPTH), .NUM_SAMPLES(NS), .FFT_OUT_BASE(FFT_BASE), .FIR_OUT_BASE(FIR_BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .acc_fft_get(acc_fft_get), .acc_fir_get(acc_fir_get),
    .acc_fft_put(acc_fft_put), .acc_fir_put(acc_fir_put),
    .acc_fft_data_in(acc_fft_data_in), .acc_fir_data_in(acc_fir_data_in),
    .acc_fft_data_out(acc_fft_data_out), .acc_fir_data_out(acc_fir_data_out),
    .fft_enable(fft_enable), .fir_enable(fir_enable),
    .to_fft_empty(to_fft_empty), .to_fir_empty(to_fir_empty),
    .from_fft_full(from_fft_full), .from_fir_full(from_fir_full),
    .data_bus(data_bus), .ram_read_enable(ram_read_enable),
    .ram_write_enable(ram_write_enable), .addr(addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: sample contents of each FIFO and the expected next RAM addresses.
  logic [31:0] fftin_q[$], firin_q[$], fftout_q[$], firout_q[$];
  logic [31:0] wr_log[$];
  int          exp_rd = 0, fft_idx = 0, fir_idx = 0;
  bit          rd_now = 0, wr_fft_now = 0, wr_fir_now = 0;
  logic [31:0] rd_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] head(input logic [31:0] q[$]);
    return (q.size() > 0) ? q[0] : 32'd0;
  endfunction

  // Monitor: compares DUT outputs with the model and consumes expected writebacks.
  always @(negedge clk) begin
    rd_now = 0; wr_fft_now = 0; wr_fir_now = 0;
    if (reset) begin
      check("strobe_excl", 32'(ram_read_enable && ram_write_enable), 32'd0);
      check("fft_head", acc_fft_data_out, head(fftin_q));
      check("fir_head", acc_fir_data_out, head(firin_q));
      check("fft_in_empty", {30'd0, to_fft_empty, fft_enable}, {30'd0, fftin_q.size() == 0, fftin_q.size() != 0});
      check("fir_in_empty", {30'd0, to_fir_empty, fir_enable}, {30'd0, firin_q.size() == 0, firin_q.size() != 0});
      check("fft_out_full", 32'(from_fft_full), 32'(fftout_q.size() >= DEPTH));
      check("fir_out_full", 32'(from_fir_full), 32'(firout_q.size() >= DEPTH));
      if (ram_read_enable) begin
        check("rd_in_range", 32'(exp_rd < NS), 32'd1);
        check("rd_addr", addr, 32'(exp_rd));
        rd_val = 32'(exp_rd) + 32'd100;
        exp_rd++;
        rd_now = 1;
      end
      if (ram_write_enable) begin
        wr_log.push_back(addr);
        if (addr >= FIR_BASE) begin
          check("fir_wr_expected", 32'(firout_q.size() > 0), 32'd1);
          if (firout_q.size() > 0) begin
            check("fir_wr_addr", addr, FIR_BASE + 32'(fir_idx));
            check("fir_wr_data", data_bus, firout_q.pop_front());
            fir_idx = (fir_idx + 1) % NS;
            wr_fir_now = 1;
          end
        end else begin
          check("fft_wr_expected", 32'(fftout_q.size() > 0), 32'd1);
          if (fftout_q.size() > 0) begin
            check("fft_wr_addr", addr, FFT_BASE + 32'(fft_idx));
            check("fft_wr_data", data_bus, fftout_q.pop_front());
            fft_idx = (fft_idx + 1) % NS;
            wr_fft_now = 1;
          end
        end
      end
    end
  end

  task automatic step_wait();
    @(negedge clk);
    #1;
  endtask

  // Drive accelerator inputs for the coming edge and apply their effect to the model.
  task automatic drive(input bit gf, input bit gr, input bit pf, input bit pr,
                       input logic [31:0] df, input logic [31:0] dr);
    acc_fft_get = gf; acc_fir_get = gr; acc_fft_put = pf; acc_fir_put = pr;
    acc_fft_data_in = df; acc_fir_data_in = dr;
    if (reset) begin
      if (gf && fftin_q.size() > 0) void'(fftin_q.pop_front());
      if (gr && firin_q.size() > 0) void'(firin_q.pop_front());
      if (rd_now) begin
        fftin_q.push_back(rd_val);
        firin_q.push_back(rd_val);
      end
      if (pf && (fftout_q.size() + int'(wr_fft_now)) < DEPTH) fftout_q.push_back(df);
      if (pr && (firout_q.size() + int'(wr_fir_now)) < DEPTH) firout_q.push_back(dr);
    end
  endtask

  task automatic step(input bit gf, input bit gr, input bit pf, input bit pr,
                      input logic [31:0] df, input logic [31:0] dr);
    step_wait();
    drive(gf, gr, pf, pr, df, dr);
  endtask

  task automatic model_reset();
    fftin_q.delete(); firin_q.delete(); fftout_q.delete(); firout_q.delete();
    exp_rd = 0; fft_idx = 0; fir_idx = 0;
    rd_now = 0; wr_fft_now = 0; wr_fir_now = 0;
  endtask

  initial begin
    // Reset values while reset is held low.
    repeat (3) step_wait();
    check("rst_rd_en", 32'(ram_read_enable), 32'd0);
    check("rst_wr_en", 32'(ram_write_enable), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_empty", {30'd0, to_fft_empty, to_fir_empty}, 32'd3);
    check("rst_full", {30'd0, from_fft_full, from_fir_full}, 32'd0);
    check("rst_enable", {30'd0, fft_enable, fir_enable}, 32'd0);
    check("rst_fft_data", acc_fft_data_out, 32'd0);
    check("rst_fir_data", acc_fir_data_out, 32'd0);

    // Fill: no gets, so exactly DEPTH reads then a stall.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0, 0);
    step_wait();
    check("fill_reads", 32'(exp_rd), 32'(DEPTH));
    check("fill_stall", 32'(ram_read_enable), 32'd0);
    check("fill_fft_head", acc_fft_data_out, 32'd100);
    check("fill_fir_head", acc_fir_data_out, 32'd100);

    // Drain: first get frees a slot and the read restarts in the next cycle.
    drive(1, 1, 0, 0, 0, 0);
    step_wait();
    check("read_resume", 32'(ram_read_enable), 32'd1);
    drive(1, 1, 0, 0, 0, 0);
    repeat (40) step(1, 1, 0, 0, 0, 0);
    step_wait();
    check("reads_stop", 32'(exp_rd), 32'(NS));
    check("drained_empty", {30'd0, to_fft_empty, to_fir_empty}, 32'd3);

    // Writeback of 5,6,7 with one-cycle latency.
    drive(1, 1, 1, 0, 32'd5, 0);
    step_wait();
    check("wb_not_yet", 32'(ram_write_enable), 32'd0);
    drive(0, 0, 1, 0, 32'd6, 0);
    step_wait();
    check("wb_first_addr", {31'd0, ram_write_enable} ^ addr, 32'd1 ^ FFT_BASE);
    drive(0, 0, 1, 0, 32'd7, 0);
    repeat (6) step(0, 0, 0, 0, 0, 0);

    // Contention: FFT wins, FIR follows.
    wr_log.delete();
    step(0, 0, 1, 1, 32'h0A, 32'h0B);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    check("prio_count", 32'(wr_log.size()), 32'd2);
    check("prio_first", (wr_log.size() > 0) ? wr_log[0] : 32'hFFFF_FFFF, FFT_BASE + 32'd3);
    check("prio_second", (wr_log.size() > 1) ? wr_log[1] : 32'hFFFF_FFFF, FIR_BASE);

    // FFT saturates the bus, so the FIR output FIFO fills and drops puts.
    repeat (24) step(0, 0, 1, 1, $urandom, $urandom);
    step_wait();
    check("fir_full", 32'(from_fir_full), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (40) step(0, 0, 0, 0, 0, 0);
    check("full_drained", 32'(fftout_q.size() + firout_q.size()), 32'd0);

    // Reset during a write cycle.
    step(0, 0, 1, 0, $urandom, 0);
    step(0, 0, 0, 0, 0, 0);
    step_wait();
    check("pre_reset_write", 32'(ram_write_enable), 32'd1);
    reset = 1'b0;
    acc_fft_put = 1'b0;
    #1;
    check("reset_abort_wr", 32'(ram_write_enable), 32'd0);
    check("reset_abort_addr", addr, 32'd0);
    model_reset();
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step_wait();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Randomized traffic with reads, gets and puts interleaved.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom, $urandom);
    repeat (80) step(1, 1, 0, 0, 0, 0);
    check("rand_reads", 32'(exp_rd), 32'(NS));
    check("rand_drained", 32'(fftout_q.size() + firout_q.size() + fftin_q.size() + firin_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
